// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and helpers for the memory controller
// Purpose: channel state encoding and index-width helper used by mem_controller and rr_pick.
// Ports: none (package).
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAYING   = 2'd3
    } ch_state_e;

    // Width of an index into n items; never zero so a single consumer still gets a 1-bit index.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin first-set-bit finder
// Purpose: combinationally return the first set bit of mask, searching upward from start with wrap.
// Ports:
//   mask  in  [N]   request mask
//   start in  [IW]  index searched first
//   found out 1     some bit of mask is set
//   idx   out [IW]  index of the first set bit at or after start (wrapping)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    int            pos;
    logic [IW-1:0] pos_i;

    // Walk from the farthest candidate back to start so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        pos_i = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos   = (int'(start) + k) % N;
            pos_i = pos[IW-1:0];
            if (mask[pos_i]) begin
                found = 1'b1;
                idx   = pos_i;
            end
        end
    end

endmodule

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - multi-channel round-robin memory request controller
// Purpose: arbitrates NUM_CONSUMERS read/write requesters onto NUM_CHANNELS memory channels.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   consumer_read_valid/address       per-consumer read request
//   consumer_read_ready/data          per-consumer read acknowledge and returned data
//   consumer_write_valid/address/data per-consumer write request
//   consumer_write_ready              per-consumer write acknowledge
//   mem_read_valid/address, mem_read_ready/data             per-channel memory read port
//   mem_write_valid/address/data, mem_write_ready           per-channel memory write port
//   channel_busy                      channel not in IDLE
module mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready,
    output logic [NUM_CHANNELS-1:0]                  channel_busy
);

    localparam int CW = idx_bits(NUM_CONSUMERS);
    localparam bit WE = (WRITE_ENABLE != 0);

    logic [NUM_CONSUMERS-1:0]          req;
    logic [NUM_CONSUMERS-1:0]          held;
    logic [NUM_CONSUMERS-1:0]          rd_ready_c;
    logic [NUM_CONSUMERS-1:0]          wr_ready_c;
    ch_state_e [NUM_CHANNELS-1:0]      ch_state;
    logic [NUM_CHANNELS-1:0][CW-1:0]   ch_cur;
    logic [NUM_CHANNELS-1:0]           ch_is_write;
    logic [NUM_CHANNELS-1:0]           grant_valid;
    logic [NUM_CHANNELS-1:0][CW-1:0]   grant_idx;
    logic [CW-1:0]                     rr_ptr;
    logic [CW-1:0]                     rr_ptr_next;
    logic [CW-1:0]                     hi_idx;
    logic                              any_grant;

    // Write requests never compete in a read-only build.
    assign req = consumer_read_valid | (WE ? consumer_write_valid : '0);

    // Consumers already owned by a busy channel are not eligible.
    always_comb begin
        held = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (ch_state[ch] != IDLE) held[ch_cur[ch]] = 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] mask_in;
        logic [NUM_CONSUMERS-1:0] mask_out;
        logic [NUM_CONSUMERS-1:0] onehot;
        logic                     found;
        logic [CW-1:0]            idx;
        logic                     grant;
        ch_state_e                state_q;
        ch_state_e                state_d;
        logic [CW-1:0]            cur_q;
        logic                     is_write_q;
        logic                     rd_valid_q;
        logic [ADDR_BITS-1:0]     rd_addr_q;
        logic                     wr_valid_q;
        logic [ADDR_BITS-1:0]     wr_addr_q;
        logic [DATA_BITS-1:0]     wr_data_q;

        // Lower-indexed channels pick first; each passes on the mask minus its own grant.
        if (ch == 0) begin : g_first
            assign mask_in = req & ~held;
        end else begin : g_next
            assign mask_in = g_ch[ch-1].mask_out;
        end

        rr_pick #(.N(NUM_CONSUMERS), .IW(CW)) u_pick (
            .mask  (mask_in),
            .start (rr_ptr),
            .found (found),
            .idx   (idx)
        );

        always_comb begin
            onehot      = '0;
            onehot[idx] = 1'b1;
        end

        assign grant    = (state_q == IDLE) && found;
        assign mask_out = grant ? (mask_in & ~onehot) : mask_in;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) state_q <= IDLE;
            else          state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                IDLE:       if (grant) state_d = consumer_read_valid[idx] ? READ_WAIT : WRITE_WAIT;
                READ_WAIT:  if (mem_read_ready[ch]) state_d = RELAYING;
                WRITE_WAIT: if (mem_write_ready[ch]) state_d = RELAYING;
                RELAYING: begin
                    if (!(is_write_q ? consumer_write_valid[cur_q] : consumer_read_valid[cur_q]))
                        state_d = IDLE;
                end
                default:    state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cur_q      <= '0;
                is_write_q <= 1'b0;
                rd_valid_q <= 1'b0;
                rd_addr_q  <= '0;
                wr_valid_q <= 1'b0;
                wr_addr_q  <= '0;
                wr_data_q  <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (grant) begin
                            cur_q <= idx;
                            // Read wins when a consumer raises both requests together.
                            if (consumer_read_valid[idx]) begin
                                is_write_q <= 1'b0;
                                rd_valid_q <= 1'b1;
                                rd_addr_q  <= consumer_read_address[idx];
                            end else begin
                                is_write_q <= 1'b1;
                                wr_valid_q <= 1'b1;
                                wr_addr_q  <= consumer_write_address[idx];
                                wr_data_q  <= consumer_write_data[idx];
                            end
                        end
                    end
                    READ_WAIT:  if (mem_read_ready[ch]) rd_valid_q <= 1'b0;
                    WRITE_WAIT: if (mem_write_ready[ch]) wr_valid_q <= 1'b0;
                    default: ;
                endcase
            end
        end

        assign ch_state[ch]          = state_q;
        assign ch_cur[ch]            = cur_q;
        assign ch_is_write[ch]       = is_write_q;
        assign grant_valid[ch]       = grant;
        assign grant_idx[ch]         = idx;
        assign channel_busy[ch]      = (state_q != IDLE);
        assign mem_read_valid[ch]    = rd_valid_q;
        assign mem_read_address[ch]  = rd_addr_q;
        assign mem_write_valid[ch]   = WE ? wr_valid_q : 1'b0;
        assign mem_write_address[ch] = WE ? wr_addr_q : '0;
        assign mem_write_data[ch]    = WE ? wr_data_q : '0;
    end

    // Consumer acknowledges are a decode of which channel is relaying for whom.
    always_comb begin
        rd_ready_c = '0;
        wr_ready_c = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (ch_state[ch] == RELAYING) begin
                if (ch_is_write[ch]) wr_ready_c[ch_cur[ch]] = 1'b1;
                else                 rd_ready_c[ch_cur[ch]] = 1'b1;
            end
        end
    end

    assign consumer_read_ready  = rd_ready_c;
    assign consumer_write_ready = WE ? wr_ready_c : '0;

    // Returned data is captured only when a read completes, otherwise it holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            consumer_read_data <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (ch_state[ch] == READ_WAIT && mem_read_ready[ch])
                    consumer_read_data[ch_cur[ch]] <= mem_read_data[ch];
            end
        end
    end

    // Pointer moves just past the numerically highest consumer granted this cycle.
    always_comb begin
        any_grant = 1'b0;
        hi_idx    = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (grant_valid[ch]) begin
                any_grant = 1'b1;
                if (grant_idx[ch] >= hi_idx) hi_idx = grant_idx[ch];
            end
        end
        rr_ptr_next = (int'(hi_idx) == NUM_CONSUMERS - 1) ? '0 : hi_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       rr_ptr <= '0;
        else if (any_grant) rr_ptr <= rr_ptr_next;
    end

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed self-checking bench for mem_controller
module tb_mem_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [3:0]      cons_rv, cons_wv;
    logic [3:0][7:0] cons_ra, cons_wa, cons_wd;

    // dut_a: 1 channel, writes enabled
    logic [3:0]      a_crr, a_cwr;
    logic [3:0][7:0] a_crd;
    logic [0:0]      a_mrv, a_mrr, a_mwv, a_mwr, a_busy;
    logic [0:0][7:0] a_mra, a_mrd, a_mwa, a_mwd;

    // dut_b: 2 channels
    logic [3:0]      b_crr, b_cwr;
    logic [3:0][7:0] b_crd;
    logic [1:0]      b_mrv, b_mrr, b_mwv, b_mwr, b_busy;
    logic [1:0][7:0] b_mra, b_mrd, b_mwa, b_mwd;

    // ro: read-only build
    logic [3:0]      ro_crr, ro_cwr;
    logic [3:0][7:0] ro_crd;
    logic [0:0]      ro_mrv, ro_mrr, ro_mwv, ro_mwr, ro_busy;
    logic [0:0][7:0] ro_mra, ro_mrd, ro_mwa, ro_mwd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .consumer_read_valid(cons_rv), .consumer_read_address(cons_ra),
        .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
        .consumer_write_valid(cons_wv), .consumer_write_address(cons_wa),
        .consumer_write_data(cons_wd), .consumer_write_ready(a_cwr),
        .mem_read_valid(a_mrv), .mem_read_address(a_mra),
        .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
        .mem_write_valid(a_mwv), .mem_write_address(a_mwa), .mem_write_data(a_mwd),
        .mem_write_ready(a_mwr), .channel_busy(a_busy)
    );

    mem_controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .consumer_read_valid(cons_rv), .consumer_read_address(cons_ra),
        .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
        .consumer_write_valid(cons_wv), .consumer_write_address(cons_wa),
        .consumer_write_data(cons_wd), .consumer_write_ready(b_cwr),
        .mem_read_valid(b_mrv), .mem_read_address(b_mra),
        .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
        .mem_write_valid(b_mwv), .mem_write_address(b_mwa), .mem_write_data(b_mwd),
        .mem_write_ready(b_mwr), .channel_busy(b_busy)
    );

    mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset_n(reset_n),
        .consumer_read_valid(cons_rv), .consumer_read_address(cons_ra),
        .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
        .consumer_write_valid(cons_wv), .consumer_write_address(cons_wa),
        .consumer_write_data(cons_wd), .consumer_write_ready(ro_cwr),
        .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
        .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
        .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa), .mem_write_data(ro_mwd),
        .mem_write_ready(ro_mwr), .channel_busy(ro_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cons_rv = '0; cons_wv = '0;
        cons_ra = '0; cons_wa = '0; cons_wd = '0;
        a_mrr = '0; a_mrd = '0; a_mwr = '0;
        b_mrr = '0; b_mrd = '0; b_mwr = '0;
        ro_mrr = '0; ro_mrd = '0; ro_mwr = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   rr_exp [5];
        bit   ok;
        logic [1:0] gi;

        rr_exp = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        check("rst_mrv", a_mrv, 0);
        check("rst_busy", a_busy, 0);
        check("rst_crr", a_crr, 0);
        check("rst_crd", a_crd, 0);
        check("rst_mwv", a_mwv, 0);

        // Single read: consumer 2, addr 0x3C, memory answers one cycle after seeing valid
        cons_ra[2] = 8'h3C;
        cons_rv    = 4'b0100;
        step();
        check("rd_mrv", a_mrv, 1);
        check("rd_mra", a_mra[0], 8'h3C);
        check("rd_busy", a_busy, 1);
        check("rd_crr_early", a_crr, 0);
        step();
        check("rd_wait_mrv", a_mrv, 1);
        check("rd_wait_crr", a_crr, 0);
        a_mrd[0] = 8'hA5;
        a_mrr[0] = 1'b1;
        step();
        a_mrr[0] = 1'b0;
        check("rd_crr", a_crr, 4'b0100);
        check("rd_crd", a_crd[2], 8'hA5);
        check("rd_mrv_drop", a_mrv, 0);
        step();
        check("rd_crr_hold", a_crr, 4'b0100);
        cons_rv = '0;
        step();
        check("rd_crr_rel", a_crr, 0);
        check("rd_busy_rel", a_busy, 0);
        // Memory ready while idle is ignored
        a_mrd[0] = 8'hEE;
        a_mrr[0] = 1'b1;
        step();
        a_mrr[0] = 1'b0;
        check("idle_ready_crd", a_crd[2], 8'hA5);
        check("idle_ready_busy", a_busy, 0);

        // Stalled memory for 20 cycles, consumer drops valid during the wait
        cons_ra[1] = 8'h77;
        cons_rv    = 4'b0010;
        step();
        for (int i = 0; i < 20; i++) begin
            check("stall_mrv", a_mrv, 1);
            check("stall_mra", a_mra[0], 8'h77);
            check("stall_crr", a_crr, 0);
            step();
        end
        cons_rv = '0;
        step();
        check("abort_mrv", a_mrv, 1);
        a_mrd[0] = 8'h3E;
        a_mrr[0] = 1'b1;
        step();
        a_mrr[0] = 1'b0;
        check("stall_done_crr", a_crr, 4'b0010);
        check("stall_done_crd", a_crd[1], 8'h3E);
        check("other_crd_held", a_crd[2], 8'hA5);
        step();
        check("stall_rel_busy", a_busy, 0);

        // Round-robin with one channel and four continuously requesting consumers
        do_reset();
        for (int i = 0; i < 4; i++) cons_ra[i] = 8'(i);
        cons_rv = 4'hF;
        for (int g = 0; g < 5; g++) begin
            ok = 1'b0;
            for (int t = 0; t < 10 && !ok; t++) begin
                if (a_mrv[0]) ok = 1'b1;
                else step();
            end
            check("rr_wait", ok, 1);
            check("rr_grant", a_mra[0], rr_exp[g]);
            gi = a_mra[0][1:0];
            a_mrd[0] = 8'hC0 + 8'(gi);
            a_mrr[0] = 1'b1;
            step();
            a_mrr[0] = 1'b0;
            check("rr_crr", a_crr, 4'b0001 << gi);
            check("rr_crd", a_crd[gi], 8'hC0 + 8'(gi));
            cons_rv[gi] = 1'b0;
            step();
            cons_rv[gi] = 1'b1;
        end

        // Read/write collision on consumer 0
        do_reset();
        cons_ra[0] = 8'h20;
        cons_wa[0] = 8'h10;
        cons_wd[0] = 8'h55;
        cons_rv    = 4'b0001;
        cons_wv    = 4'b0001;
        step();
        check("col_mrv", a_mrv, 1);
        check("col_mra", a_mra[0], 8'h20);
        check("col_mwv_first", a_mwv, 0);
        a_mrd[0] = 8'h99;
        a_mrr[0] = 1'b1;
        step();
        a_mrr[0] = 1'b0;
        check("col_crr", a_crr, 4'b0001);
        check("col_cwr_early", a_cwr, 0);
        cons_rv = '0;
        step();
        check("col_idle", a_busy, 0);
        step();
        check("col_mwv", a_mwv, 1);
        check("col_mwa", a_mwa[0], 8'h10);
        check("col_mwd", a_mwd[0], 8'h55);
        check("col_mrv_off", a_mrv, 0);
        a_mwr[0] = 1'b1;
        step();
        a_mwr[0] = 1'b0;
        check("col_cwr", a_cwr, 4'b0001);
        check("col_mwv_drop", a_mwv, 0);
        cons_wv = '0;
        step();
        check("col_cwr_rel", a_cwr, 0);
        check("col_busy_rel", a_busy, 0);

        // Two channels, consumers 1 and 3 in the same cycle
        do_reset();
        cons_ra[1] = 8'h11;
        cons_ra[3] = 8'h33;
        cons_rv    = 4'b1010;
        step();
        check("ch2_mrv", b_mrv, 2'b11);
        check("ch2_mra0", b_mra[0], 8'h11);
        check("ch2_mra1", b_mra[1], 8'h33);
        check("ch2_busy", b_busy, 2'b11);
        b_mrd[1] = 8'h5A;
        b_mrr    = 2'b10;
        step();
        b_mrr    = 2'b00;
        check("ch2_crr", b_crr, 4'b1000);
        check("ch2_crd3", b_crd[3], 8'h5A);
        check("ch2_mrv_after", b_mrv, 2'b01);

        // Reset asserted while a read waits on memory
        do_reset();
        cons_ra[2] = 8'h3C;
        cons_rv    = 4'b0100;
        step();
        check("rstw_pre_mrv", a_mrv, 1);
        reset_n = 1'b0;
        #1;
        check("rstw_mrv", a_mrv, 0);
        check("rstw_mra", a_mra[0], 0);
        check("rstw_busy", a_busy, 0);
        check("rstw_crr", a_crr, 0);

        // Read-only build under write stimulus
        do_reset();
        cons_wv = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cons_wa[i] = 8'hF0 + 8'(i);
            cons_wd[i] = 8'h0F + 8'(i);
        end
        step();
        step();
        step();
        check("ro_mwv", ro_mwv, 0);
        check("ro_mwa", ro_mwa[0], 0);
        check("ro_mwd", ro_mwd[0], 0);
        check("ro_cwr", ro_cwr, 0);
        check("ro_busy", ro_busy, 0);
        check("rw_busy", a_busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
